// File: rtl/dose_pkg.sv
// Shared types and helpers for the dose scheduler: FSM states, time-field widths,
// the programmed slot record, and saturating counter arithmetic.
package dose_pkg;

    localparam int HOUR_W     = 5;
    localparam int MIN_W      = 6;
    localparam int SEC_W      = 6;
    localparam int COMP_MAX_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        ALERT    = 2'd2
    } state_t;

    // Compartment is stored at its widest size; instances keep the low COMP_W bits.
    typedef struct packed {
        logic                  enable;
        logic [HOUR_W-1:0]     hour;
        logic [MIN_W-1:0]      minute;
        logic [COMP_MAX_W-1:0] comp;
    } slot_t;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [4:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {4'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/dose_slot_table.sv
// Programmed dose slots and the per-slot time-of-day match vector.
module dose_slot_table
    import dose_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int COMP_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot,
    input  logic                         cfg_enable,
    input  logic [HOUR_W-1:0]            cfg_hour,
    input  logic [MIN_W-1:0]             cfg_minute,
    input  logic [COMP_W-1:0]            cfg_comp,
    input  logic [HOUR_W-1:0]            hours,
    input  logic [MIN_W-1:0]             minutes,
    input  logic [$clog2(NUM_SLOTS)-1:0] rd_slot,
    output logic [COMP_W-1:0]            rd_comp,
    output logic [NUM_SLOTS-1:0]         match
);

    slot_t slots_r [NUM_SLOTS];

    // Slot storage: single-cycle write of one record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_r[i] <= '0;
            end
        end else if (cfg_we) begin
            slots_r[cfg_slot] <= '{enable: cfg_enable, hour: cfg_hour, minute: cfg_minute,
                                   comp: COMP_MAX_W'(cfg_comp)};
        end else begin
            slots_r <= slots_r;
        end
    end

    // Enabled slots whose programmed time equals the current hour and minute
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            match[i] = slots_r[i].enable && (slots_r[i].hour == hours)
                       && (slots_r[i].minute == minutes);
        end
    end

    assign rd_comp = COMP_W'(slots_r[rd_slot].comp);

endmodule

// File: rtl/dose_scheduler.sv
// Dispenser sequencer: latches due slots at minute boundaries, serves them lowest
// index first through the dispense handshake, then alerts until confirm or timeout.
module dose_scheduler
    import dose_pkg::*;
#(
    parameter int NUM_SLOTS     = 4,
    parameter int COMP_W        = 2,
    parameter int ALERT_TIMEOUT = 300
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         second_pulse,
    input  logic [4:0]                   hours,
    input  logic [5:0]                   minutes,
    input  logic [5:0]                   seconds,
    input  logic                         set_mode,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot,
    input  logic                         cfg_enable,
    input  logic [4:0]                   cfg_hour,
    input  logic [5:0]                   cfg_minute,
    input  logic [COMP_W-1:0]            cfg_comp,
    output logic                         disp_req,
    output logic [COMP_W-1:0]            disp_comp,
    input  logic                         disp_done,
    input  logic                         confirm,
    output logic                         alert,
    output logic                         missed,
    output logic [7:0]                   taken_count,
    output logic [7:0]                   missed_count,
    output logic                         busy
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int TMR_W  = $clog2(ALERT_TIMEOUT + 1);

    state_t                state_r, state_s;
    logic                  tick_d_r;
    logic [NUM_SLOTS-1:0]  pending_r, pending_s, match_s, hit_s, overrun_s;
    logic [NUM_SLOTS-1:0]  grant_mask_s, cfg_mask_s;
    logic [SLOT_W-1:0]     grant_idx_s;
    logic [COMP_W-1:0]     rd_comp_s, disp_comp_r;
    logic [TMR_W-1:0]      timer_r;
    logic                  grant_s, take_s, timeout_s;
    logic                  req_s, alert_s, busy_s;
    logic                  disp_req_r, alert_r, busy_r, missed_r;
    logic [7:0]            taken_r, missed_cnt_r;
    logic [4:0]            miss_inc_s;
    logic                  boundary_s;

    dose_slot_table #(.NUM_SLOTS(NUM_SLOTS), .COMP_W(COMP_W)) u_table (
        .clk       (CLOCK_50),
        .rst_n     (reset),
        .cfg_we    (cfg_we),
        .cfg_slot  (cfg_slot),
        .cfg_enable(cfg_enable),
        .cfg_hour  (cfg_hour),
        .cfg_minute(cfg_minute),
        .cfg_comp  (cfg_comp),
        .hours     (hours),
        .minutes   (minutes),
        .rd_slot   (grant_idx_s),
        .rd_comp   (rd_comp_s),
        .match     (match_s)
    );

    // tick_d lags the pulse so the seconds field has already rolled over
    assign boundary_s = tick_d_r && (seconds == SEC_W'(0));
    assign hit_s      = (boundary_s && !set_mode) ? match_s : '0;
    assign overrun_s  = hit_s & pending_r;
    assign miss_inc_s = popcount16(16'(overrun_s)) + {4'd0, timeout_s};

    // Lowest-index pending slot wins the grant
    always_comb begin
        grant_idx_s = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            grant_idx_s = pending_r[i] ? SLOT_W'(i) : grant_idx_s;
        end
    end

    assign grant_mask_s = grant_s ? (NUM_SLOTS'(1) << grant_idx_s) : '0;
    assign cfg_mask_s   = cfg_we ? (NUM_SLOTS'(1) << cfg_slot) : '0;
    assign pending_s    = ((pending_r & ~grant_mask_s) | hit_s) & ~cfg_mask_s;

    // FSM next-state and event decode
    always_comb begin
        state_s   = state_r;
        grant_s   = 1'b0;
        take_s    = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (|pending_r) begin
                    state_s = DISPENSE;
                    grant_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            DISPENSE: begin
                if (disp_done) begin
                    state_s = ALERT;
                end else begin
                    state_s = DISPENSE;
                end
            end
            ALERT: begin
                if (confirm) begin
                    state_s = IDLE;
                    take_s  = 1'b1;
                end else if (timer_r >= TMR_W'(ALERT_TIMEOUT)) begin
                    state_s   = IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = ALERT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode from the next state so the outputs leave a register
    always_comb begin
        req_s   = (state_s == DISPENSE);
        alert_s = (state_s == ALERT);
        busy_s  = (state_s != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            disp_req_r <= 1'b0;
            alert_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            disp_req_r <= req_s;
            alert_r    <= alert_s;
            busy_r     <= busy_s;
        end
    end

    // Pending vector, served compartment, alert timer, counters
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            tick_d_r     <= 1'b0;
            pending_r    <= '0;
            disp_comp_r  <= '0;
            timer_r      <= '0;
            missed_r     <= 1'b0;
            taken_r      <= 8'd0;
            missed_cnt_r <= 8'd0;
        end else begin
            tick_d_r     <= second_pulse;
            pending_r    <= pending_s;
            disp_comp_r  <= grant_s ? rd_comp_s : disp_comp_r;
            if (state_r == DISPENSE && disp_done) begin
                timer_r <= '0;
            end else if (state_r == ALERT && tick_d_r && timer_r < TMR_W'(ALERT_TIMEOUT)) begin
                timer_r <= timer_r + TMR_W'(1);
            end else begin
                timer_r <= timer_r;
            end
            missed_r     <= timeout_s ? 1'b1 : (take_s ? 1'b0 : missed_r);
            taken_r      <= take_s ? sat_add8(taken_r, 5'd1) : taken_r;
            missed_cnt_r <= sat_add8(missed_cnt_r, miss_inc_s);
        end
    end

    assign disp_req     = disp_req_r;
    assign disp_comp    = disp_comp_r;
    assign alert        = alert_r;
    assign busy         = busy_r;
    assign missed       = missed_r;
    assign taken_count  = taken_r;
    assign missed_count = missed_cnt_r;

endmodule

// File: doc/dose_scheduler.md
# dose_scheduler

Dose scheduler for the drug dispenser. It holds a table of programmed dose times and compares it against the running time-of-day counters (hours/minutes/seconds and the one-cycle second pulse) at every minute boundary. On a match it drives the dispense mechanism with a req/done handshake, then alerts the patient until the dose is confirmed or times out. It is the only block that sequences the dispenser; it arbitrates between slots that fall due together.

## Interface
Parameters:
- NUM_SLOTS, 4: number of programmable dose slots (power of two, 2..16)
- COMP_W, 2: compartment index width
- ALERT_TIMEOUT, 300: seconds the alert may stay unconfirmed before the dose counts as missed

Ports:
- CLOCK_50  in  1  system clock; only clock
- reset  in  1  asynchronous, active-low reset
- second_pulse  in  1  one-cycle pulse per second from the seconds timebase
- hours  in  5  current hour, 0..23
- minutes  in  6  current minute, 0..59
- seconds  in  6  current second, 0..59
- set_mode  in  1  clock-set switch; 1 suppresses new matches
- cfg_we  in  1  slot write strobe
- cfg_slot  in  $clog2(NUM_SLOTS)  slot index
- cfg_enable  in  1  slot enable
- cfg_hour  in  5  dose hour
- cfg_minute  in  6  dose minute
- cfg_comp  in  COMP_W  compartment to dispense
- disp_req  out  1  dispense request
- disp_comp  out  COMP_W  compartment; valid while disp_req=1
- disp_done  in  1  dispenser finished
- confirm  in  1  synchronized, single-cycle patient acknowledge
- alert  out  1  patient alert active
- missed  out  1  sticky missed-dose indicator
- taken_count  out  8  confirmed doses, saturating
- missed_count  out  8  missed or overrun doses, saturating
- busy  out  1  state is not IDLE

## Operation
- Reset clears every slot (enable=0, time=0, comp=0), the pending vector, the timer and the counters. State is IDLE. All outputs are 0.
- tick_d is second_pulse registered, so it is high one cycle after the pulse, when seconds is already updated.
- Minute boundary: tick_d=1 and seconds==0.
- At a minute boundary with set_mode=0, every enabled slot with hour==hours and minute==minutes sets its pending bit, in any state.
- If that pending bit is already set, this is an overrun: missed_count increments once per slot, and the bit stays set.
- cfg_we writes the slot in one cycle and clears that slot's pending bit. A write to the slot being served does not alter the latched disp_comp.
- States: IDLE, DISPENSE, ALERT.
- IDLE -> DISPENSE when pending is non-zero. The controller grants the lowest-index pending slot, latches its comp into disp_comp and clears its pending bit.
- DISPENSE: disp_req=1 and disp_comp is held stable. On disp_done=1, the state goes to ALERT and disp_req drops. disp_done outside DISPENSE is ignored.
- ALERT: alert=1 and the timer is cleared on entry. The timer increments on tick_d.
  - confirm=1: taken_count++, missed<=0, go to IDLE.
  - Timer reaches ALERT_TIMEOUT: missed_count++, missed<=1, go to IDLE.
  - confirm and timeout in the same cycle: confirm wins.
- set_mode suppresses only new pending bits. In-flight service and pending service continue.
- The counters saturate at 255. If an overrun and a timeout hit missed_count in the same cycle, it adds 2, saturating.
- Reset mid-operation drops disp_req and alert immediately (asynchronous).

## Timing
- second_pulse in cycle t marks a minute boundary. tick_d is high in t+1, the pending bit is visible in t+2, and disp_req rises in t+3.
- disp_done seen high in cycle n: disp_req=0 and alert=1 from n+1.
- confirm in cycle n: alert=0 and the count is updated from n+1.
- Back-to-back slots: the next disp_req rises one cycle after returning to IDLE (one IDLE cycle between grants).
- Timeout: ALERT_TIMEOUT tick_d events after ALERT entry, plus one cycle.

## Structure
- Shared package dose_pkg: state enum (IDLE, DISPENSE, ALERT), HOUR_W=5, MIN_W=6, SEC_W=6, and the slot record typedef {enable, hour, minute, comp}.
- Sub-module dose_slot_table: the slot registers plus the combinational match vector. The top level holds the FSM, the pending vector, the priority grant, the timer and the counters.

## Test plan
- Slot 1 at 08:30 comp 2; drive time to 08:29:59, pulse -> disp_req=1 with disp_comp=2 exactly 3 cycles after the pulse. Return disp_done, confirm -> taken_count=1, alert=0.
- Slots 0 and 3 both at 12:00 -> slot 0 is served first, then slot 3 after its confirm. Two handshakes occur, in index order.
- Dose with no confirm for ALERT_TIMEOUT pulses -> missed=1 and missed_count=1. The next confirmed dose clears missed.
- Slot matched while set_mode=1 -> no pending bit and no disp_req. Set set_mode=1 during ALERT -> service completes normally.
- confirm in the same cycle as timeout -> taken_count++ and missed_count unchanged. Reset asserted during DISPENSE -> disp_req=0 immediately and all counters read 0.
- Same slot matched again while still pending, using a forced short day -> missed_count++. Rewriting the slot clears the pending bit and produces no dispense.
